// File: rtl/micro_sequencer.sv
// micro_sequencer: 32-step microcode sequencer driving an accumulator datapath.
// A program is fetched from an external ROM at rom_addr and executed one op per
// enabled cycle until HALT, TRAP or the last address completes.
// Optional build feature: define MSEQ_SKIPZ_EN to decode op 1001 as SKIPZ
// (skip the next op when acc == 0); otherwise 1001 is a NOP.
module micro_sequencer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    output logic [4:0]        rom_addr,
    input  logic [3:0]        rom_data,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] OpLoad = 4'b0001;
    localparam logic [3:0] OpHalt = 4'b0010;
    localparam logic [3:0] OpShl  = 4'b0011;
    localparam logic [3:0] OpInc  = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b0101;
    localparam logic [3:0] OpShr  = 4'b0110;
    localparam logic [3:0] OpDec  = 4'b0111;
    localparam logic [3:0] OpOut  = 4'b1000;
`ifdef MSEQ_SKIPZ_EN
    localparam logic [3:0] OpSkipz = 4'b1001;
`endif
    localparam logic [3:0] OpTrap = 4'b1111;

    localparam logic [DATA_W-1:0] AccOne = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [4:0]        pc_q;
    logic [DATA_W-1:0] acc_q;

    logic [DATA_W-1:0] acc_d;
    logic [5:0]        pc_step;  // one bit wider so stepping past address 31 is visible
    logic [4:0]        pc_d;
    logic              stop_op;
    logic              trap_op;
    logic              out_op;
    logic              finish;

    assign rom_addr = pc_q;

    // Decode the current micro-op into the next accumulator value and control effects
    always_comb begin
        acc_d   = acc_q;
        pc_step = {1'b0, pc_q} + 6'd1;
        stop_op = 1'b0;
        trap_op = 1'b0;
        out_op  = 1'b0;
        case (rom_data)
            OpLoad:  acc_d = din;
            OpHalt:  stop_op = 1'b1;
            OpShl:   acc_d = acc_q << 1;
            OpInc:   acc_d = acc_q + AccOne;
            OpAdd:   acc_d = acc_q + din;
            OpShr:   acc_d = acc_q >> 1;
            OpDec:   acc_d = acc_q - AccOne;
            OpOut:   out_op = 1'b1;
`ifdef MSEQ_SKIPZ_EN
            OpSkipz: begin
                if (acc_q == '0) begin
                    pc_step = {1'b0, pc_q} + 6'd2;
                end
            end
`endif
            OpTrap:  trap_op = 1'b1;
            default: ;
        endcase
        // pc never wraps: running off the end finishes the program with pc parked at 31
        pc_d   = pc_step[5] ? 5'd31 : pc_step[4:0];
        finish = stop_op | trap_op | pc_step[5];
    end

    // Sequencer FSM with registered status outputs; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            acc_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (ena) begin
            dout_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        pc_q    <= '0;
                        err     <= 1'b0;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    pc_q  <= pc_d;
                    if (out_op) begin
                        dout       <= acc_q;
                        dout_valid <= 1'b1;
                    end
                    if (trap_op) begin
                        err <= 1'b1;
                    end
                    if (finish) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed programs against a cycle-level behavioural model,
// plus hand-computed expectations for the key programs.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [4:0] rom_addr;
    logic [3:0] rom_data;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] rom [32];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference state: mode 0=idle 1=run 2=done
    int m_mode = 0;
    int m_pc = 0;
    int m_acc = 0;
    int m_dout = 0;
    int m_dv = 0;
    int m_done = 0;
    int m_err = 0;

    micro_sequencer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One enabled clock of the program semantics
    task automatic model_step();
        int  op;
        int  nxt;
        bit  fin;
        m_dv = 0;
        if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_pc   = 0;
                m_err  = 0;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else begin
            op  = int'(rom[m_pc]);
            nxt = m_pc + 1;
            fin = 1'b0;
            case (op)
                1:  m_acc = int'(din);
                2:  fin = 1'b1;
                3:  m_acc = (m_acc * 2) % 256;
                4:  m_acc = (m_acc + 1) % 256;
                5:  m_acc = (m_acc + int'(din)) % 256;
                6:  m_acc = m_acc / 2;
                7:  m_acc = (m_acc + 255) % 256;
                8:  begin
                    m_dout = m_acc;
                    m_dv   = 1;
                end
`ifdef MSEQ_SKIPZ_EN
                9:  if (m_acc == 0) nxt = m_pc + 2;
`endif
                15: begin
                    m_err = 1;
                    fin   = 1'b1;
                end
                default: ;
            endcase
            if (nxt > 31) begin
                nxt = 31;
                fin = 1'b1;
            end
            m_pc = nxt;
            if (fin) m_mode = 2;
        end
        m_done = (m_mode == 2) ? 1 : 0;
    endtask

    // Model advances on the same edges as the DUT, reset asynchronously
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_acc = 0; m_dout = 0; m_dv = 0; m_done = 0; m_err = 0;
        end else if (ena) begin
            model_step();
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rom_addr", int'(rom_addr), m_pc);
            check("cyc_busy", int'(busy), (m_mode == 1) ? 1 : 0);
            check("cyc_done", int'(done), m_done);
            check("cyc_err", int'(err), m_err);
            check("cyc_dout", int'(dout), m_dout);
            check("cyc_dout_valid", int'(dout_valid), m_dv);
        end
    end

    task automatic clear_rom();
        for (int a = 0; a < 32; a++) rom[a] = 4'h0;
    endtask

    // Pulse (or hold) start; index i counts negedges after the edge that sampled start
    task automatic run(input int max_cyc, input int ena_at, input int exp_hold_addr,
                       input bit hold_start,
                       output int done_k, output int dv_k, output int busy_cnt);
        done_k = -1; dv_k = -1; busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (busy) busy_cnt++;
            if (dout_valid && dv_k < 0) dv_k = i;
            if (done) begin
                done_k = i;
                break;
            end
            if (ena_at >= 0 && i == ena_at) ena = 1'b0;
            if (ena_at >= 0 && i == ena_at + 3) begin
                check("stall_rom_addr", int'(rom_addr), exp_hold_addr);
                ena = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    int dk, vk, bc;

    initial begin
        clear_rom();
        // Reset state, held across a clock edge
        @(negedge clk);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // LOAD, INC, OUT, HALT with din=5
        rom[0] = 4'h1; rom[1] = 4'h4; rom[2] = 4'h8; rom[3] = 4'h2;
        din = 8'h05;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("p1_dout", int'(dout), 8'h06);
        check("p1_dv_cycle", vk, 3);
        check("p1_done_cycle", dk, 4);
        check("p1_busy_cycles", bc, 4);

        // Same program with ena dropped for 3 cycles while pc=2
        run(40, 2, 2, 1'b0, dk, vk, bc);
        check("stall_done_cycle", dk, 7);
        check("stall_busy_cycles", bc, 7);
        check("stall_dout", int'(dout), 8'h06);

        // LOAD, SHL, ADD, SHR, DEC, OUT, HALT with din=0x81
        clear_rom();
        rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'h5; rom[3] = 4'h6;
        rom[4] = 4'h7; rom[5] = 4'h8; rom[6] = 4'h2;
        din = 8'h81;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("p2_dout", int'(dout), 8'h40);
        check("p2_done_cycle", dk, 7);

        // All NOPs: runs off the end at address 31
        clear_rom();
        run(60, -1, 0, 1'b0, dk, vk, bc);
        check("nop_done_cycle", dk, 32);
        check("nop_busy_cycles", bc, 32);
        check("nop_rom_addr", int'(rom_addr), 31);
        check("nop_err", int'(err), 0);

        // TRAP at address 2, then a clean run clears err
        rom[2] = 4'hF;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("trap_done_cycle", dk, 3);
        check("trap_err", int'(err), 1);
        clear_rom();
        rom[0] = 4'h1; rom[1] = 4'h4; rom[2] = 4'h8; rom[3] = 4'h2;
        din = 8'h05;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("trap_clear_err", int'(err), 0);
        check("trap_clear_done_cycle", dk, 4);

        // start held high: ignored in RUN/DONE, re-runs from IDLE after DONE
        run(40, -1, 0, 1'b1, dk, vk, bc);
        check("hold_done_cycle", dk, 4);
        @(negedge clk);
        din = 8'h09;
        check("hold_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("hold_rerun_busy", int'(busy), 1);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("hold_rerun_done", int'(done), 1);
        check("hold_rerun_dout", int'(dout), 8'h0A);

        // Asynchronous reset mid-run at pc=5
        clear_rom();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && rom_addr != 5'd5; i++) @(negedge clk);
        check("abort_pc_reached", int'(rom_addr), 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rom_addr", int'(rom_addr), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_dout", int'(dout), 0);
        check("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", int'(done), 0);
        rom[0] = 4'h1; rom[1] = 4'h4; rom[2] = 4'h8; rom[3] = 4'h2;
        din = 8'h05;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("abort_rerun_done_cycle", dk, 4);
        check("abort_rerun_dout", int'(dout), 8'h06);

        // LOAD, op 1001, INC, OUT, HALT
        clear_rom();
        rom[0] = 4'h1; rom[1] = 4'h9; rom[2] = 4'h4; rom[3] = 4'h8; rom[4] = 4'h2;
        din = 8'h00;
        run(40, -1, 0, 1'b0, dk, vk, bc);
`ifdef MSEQ_SKIPZ_EN
        check("skipz_zero_dout", int'(dout), 8'h00);
        check("skipz_zero_done_cycle", dk, 4);
`else
        check("skipz_nop_dout", int'(dout), 8'h01);
        check("skipz_nop_done_cycle", dk, 5);
`endif
        din = 8'h07;
        run(40, -1, 0, 1'b0, dk, vk, bc);
        check("skipz_nonzero_dout", int'(dout), 8'h08);
        check("skipz_nonzero_done_cycle", dk, 5);

        // Skip from address 30 finishes the program
`ifdef MSEQ_SKIPZ_EN
        clear_rom();
        rom[0] = 4'h1; rom[30] = 4'h9;
        din = 8'h00;
        run(60, -1, 0, 1'b0, dk, vk, bc);
        check("skipz_end_done_cycle", dk, 31);
        check("skipz_end_rom_addr", int'(rom_addr), 31);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
